// File: rtl/micro_sequencer.sv
// micro_sequencer: closed-loop next-address sequencer for the microprogrammed
// control unit. It registers the next microstore address from the next-state
// fields of the control word and the status lines. A wait state that lasts too
// long forces a trap address and sets a sticky fault flag.
//
// Ports:
//   Clk      - clock; all state changes happen on the rising edge
//   Reset_n  - asynchronous active-low reset
//   N        - next-state opcode (n2n1n0)
//   Inv      - invert the selected status
//   S        - status select (0 MOC, 1 Cond, 2 Ext, 3 constant 1)
//   CrAddr   - branch target (cr field)
//   EncAddr  - instruction-encoder start address
//   MOC      - memory operation complete
//   Cond     - condition-tester result
//   Ext      - external/interrupt request
//   Hold     - freeze all sequencer state
//   Address  - registered microstore address
//   Sel      - registered source of Address (0 enc, 1 fixed, 2 cr, 3 incr)
//   Fault    - sticky wait-timeout flag
module micro_sequencer #(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned RESET_ADDR = 0,
    parameter int unsigned TRAP_ADDR  = 63,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [2:0]        N,
    input  logic              Inv,
    input  logic [1:0]        S,
    input  logic [ADDR_W-1:0] CrAddr,
    input  logic [ADDR_W-1:0] EncAddr,
    input  logic              MOC,
    input  logic              Cond,
    input  logic              Ext,
    input  logic              Hold,
    output logic [ADDR_W-1:0] Address,
    output logic [1:0]        Sel,
    output logic              Fault
);

    typedef enum logic [2:0] {
        OP_ENC   = 3'b000,
        OP_RST   = 3'b001,
        OP_CR    = 3'b010,
        OP_INC   = 3'b011,
        OP_BR_CR = 3'b100,
        OP_BR_EN = 3'b101,
        OP_WAIT  = 3'b110,
        OP_BR_RS = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        SEL_ENC = 2'd0,
        SEL_FIX = 2'd1,
        SEL_CR  = 2'd2,
        SEL_INC = 2'd3
    } sel_e;

    localparam int unsigned CNT_W = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] RST_A  = ADDR_W'(RESET_ADDR);
    localparam logic [ADDR_W-1:0] TRAP_A = ADDR_W'(TRAP_ADDR);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic              TO_EN = (TIMEOUT != 0);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] incr_q;
    sel_e              sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fault_q, fault_d;
    logic              sts, t;
    op_e               op;

    assign op = op_e'(N);

    always_comb begin
        sts     = 1'b1;
        t       = 1'b0;
        addr_d  = addr_q;
        sel_d   = sel_q;
        cnt_d   = '0;
        fault_d = fault_q;

        case (S)
            2'd0:    sts = MOC;
            2'd1:    sts = Cond;
            2'd2:    sts = Ext;
            default: sts = 1'b1;
        endcase
        t = sts ^ Inv;

        if (Hold) begin
            cnt_d = cnt_q;
        end else if (TO_EN && op == OP_WAIT && !t && cnt_q == WAIT_LAST) begin
            addr_d  = TRAP_A;
            sel_d   = SEL_FIX;
            fault_d = 1'b1;
        end else begin
            // Unknown opcodes fall into the default and behave as a plain increment.
            case (op)
                OP_ENC: begin addr_d = EncAddr; sel_d = SEL_ENC; end
                OP_RST: begin addr_d = RST_A;   sel_d = SEL_FIX; end
                OP_CR:  begin addr_d = CrAddr;  sel_d = SEL_CR;  end
                OP_BR_CR: begin
                    if (t) begin addr_d = CrAddr; sel_d = SEL_CR;  end
                    else   begin addr_d = incr_q; sel_d = SEL_INC; end
                end
                OP_BR_EN: begin
                    if (t) begin addr_d = EncAddr; sel_d = SEL_ENC; end
                    else   begin addr_d = incr_q;  sel_d = SEL_INC; end
                end
                OP_WAIT: begin
                    if (t) begin
                        addr_d = incr_q;
                        sel_d  = SEL_INC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                OP_BR_RS: begin
                    if (t) begin addr_d = RST_A;  sel_d = SEL_FIX; end
                    else   begin addr_d = incr_q; sel_d = SEL_INC; end
                end
                default: begin addr_d = incr_q; sel_d = SEL_INC; end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_q  <= RST_A;
            incr_q  <= RST_A + 1'b1;
            sel_q   <= SEL_FIX;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            incr_q  <= addr_d + 1'b1;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign Address = addr_q;
    assign Sel     = sel_q;
    assign Fault   = fault_q;

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Next-address sequencer for the microprogrammed control unit.
- Consumes the next-state fields of the registered control word (n2n1n0, inv, s1s0, cr[5:0]), the instruction-encoder address and the status lines.
- Registers the next microstore address and drives it into the microstore Address input.
- Replaces the free-running incrementer and the manual mux select with a closed-loop sequencer, including a MOC wait timeout.

Parameters:
- ADDR_W, 6, microaddress width; all addresses wrap modulo 2^ADDR_W.
- RESET_ADDR, 0, address loaded on reset (fetch/reset microinstruction).
- TRAP_ADDR, 63, address forced on wait timeout.
- TIMEOUT, 16, maximum cycles held in a wait state; 0 disables the timeout.

Ports:
- Clk  in  1  clock; all state changes on posedge.
- Reset_n  in  1  asynchronous active-low reset.
- N  in  3  next-state opcode (control word n2n1n0).
- Inv  in  1  invert the selected status.
- S  in  2  status select.
- CrAddr  in  ADDR_W  branch target (control word cr field).
- EncAddr  in  ADDR_W  instruction-encoder start address.
- MOC  in  1  memory operation complete.
- Cond  in  1  condition-tester result.
- Ext  in  1  external/interrupt request.
- Hold  in  1  freeze the sequencer.
- Address  out  ADDR_W  registered microstore address.
- Sel  out  2  registered source of Address: 0 = encoder, 1 = fixed, 2 = cr, 3 = incr.
- Fault  out  1  sticky wait-timeout flag.

Behaviour:
- Reset (async, Reset_n = 0):
  - Address = RESET_ADDR, Sel = 1, Incr = RESET_ADDR+1, WaitCnt = 0, Fault = 0.
  - Takes effect immediately, mid-wait included.
  - First posedge after release evaluates N normally.
- Internal registers:
  - Incr always equals Address+1 modulo 2^ADDR_W, so 63 -> 0 at ADDR_W = 6.
  - WaitCnt is ADDR_W+2 bits wide.
- Status select: sts = (S==0 ? MOC : S==1 ? Cond : S==2 ? Ext : 1); t = sts ^ Inv.
- Next address per N, sampled at posedge; latency 1 cycle:
  - 000: EncAddr (Sel 0).
  - 001: RESET_ADDR (Sel 1).
  - 010: CrAddr (Sel 2).
  - 011: Incr (Sel 3).
  - 100: t ? CrAddr (Sel 2) : Incr (Sel 3).
  - 101: t ? EncAddr (Sel 0) : Incr (Sel 3).
  - 110 (wait): t ? Incr (Sel 3) : hold Address (Sel unchanged).
  - 111: t ? RESET_ADDR (Sel 1) : Incr (Sel 3).
- Wait counter:
  - Increments each cycle N = 110 with t = 0.
  - Clears on any other cycle, or when t = 1.
  - If TIMEOUT != 0 and WaitCnt == TIMEOUT-1 while N = 110 and t = 0: Address <= TRAP_ADDR, Sel <= 1, Fault <= 1, WaitCnt <= 0.
  - Hence exactly TIMEOUT cycles are spent holding before the trap.
- Fault is sticky until reset; later traps leave it at 1.
- Priority: Reset_n > Hold > timeout trap > N decode.
- Hold = 1 freezes Address, Sel, Incr, WaitCnt and Fault; status is ignored.
- Inputs are purely synchronous; no combinational path from any input to an output.
- Undefined or X on N must not corrupt state in simulation; treat it as 011.

Test Plan:
- Reset_n low at t = 3 with Clk idle -> Address = 0, Sel = 1, Fault = 0 immediately. Release, N = 011 for 5 edges -> Address 1, 2, 3, 4, 5; Sel = 3.
- Address = 62, N = 011 for 3 edges -> 63, 0, 1 (wrap).
- N = 100, S = 01, CrAddr = 40. With Cond = 1, Inv = 0 -> 40. Then Cond = 1, Inv = 1 -> 41 (Incr).
- N = 110, S = 00 at Address = 3:
  - MOC = 0 for 4 edges -> Address stays 3.
  - MOC = 1 -> 4, WaitCnt = 0.
  - MOC = 0 for 16 edges at Address = 7 -> Address = 63, Sel = 1, Fault = 1.
  - Then N = 001 -> Address = 0, Fault stays 1.
- N = 000, EncAddr = 17, Hold = 1 for 3 edges -> Address unchanged. Hold = 0 -> 17, Sel = 0.
- Mid-wait (WaitCnt = 9): Reset_n pulse low -> Address = 0, Fault = 0. A following 16-cycle wait traps only after the full 16 cycles.
